pez_cpa_stream: RTL and testbench

- Parametrised successor to the final-stage PE of the scalable radix-2^R Montgomery datapath.
- Accepts one operation as a stream of NWORDS words. Each word carries the carry-save pair (SR_S, SR_C), the shifted modulus/multiple word (SM) with its low R bits substituted by the digit SM_LO, and an injected bit FF.
- Resolves each word to binary with an inter-word carry, and emits result words over a valid/ready stream.
- Adds what the previous block lacked: reset, a configurable inter-word gap, backpressure, a last-word flag, and an optional final-reduction decision.

---
 rtl/pez_pkg.sv | 31 +++
 rtl/pez_cpa_stream_if.sv | 43 ++++
 rtl/pez_word_add.sv | 23 ++
 rtl/pez_cpa_stream.sv | 183 ++++++++++++++++++
 tb/tb_pez_cpa_stream.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pez_pkg.sv
// Shared types and sizing helpers for the pez_cpa_stream word-serial CPA stage.
// Optional feature macro: PEZ_FINAL_CMP_EN (adds the final result-vs-modulus decision).
package pez_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCEPT,
    ST_GAP,
    ST_DRAIN
  } pez_state_e;

  // Bits needed to index n items (never less than 1).
  function automatic int unsigned clogb2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  // Default configuration of the stage.
  localparam int unsigned K_DEF      = 1024;
  localparam int unsigned W_DEF      = 16;
  localparam int unsigned R_DEF      = 2;
  localparam int unsigned NWORDS_DEF = K_DEF / W_DEF;
  localparam int unsigned GAP_DEF    = W_DEF / 2 - 2;
  localparam int unsigned CNT_W      = clogb2(NWORDS_DEF);
  localparam int unsigned GAP_W      = clogb2(GAP_DEF + 1);

endpackage

// File: rtl/pez_cpa_stream_if.sv
// Word stream interface of pez_cpa_stream: control, input words and result words.
// Optional feature macro: PEZ_FINAL_CMP_EN (adds M_IN / NEED_SUB).
interface pez_cpa_stream_if #(
  parameter int unsigned W = 16,
  parameter int unsigned R = 2
);
  logic         START;
  logic         BUSY;
  logic         IN_VALID;
  logic         IN_READY;
  logic [W-1:0] SR_S;
  logic [W-1:0] SR_C;
  logic [W-1:0] SM;
  logic [R-1:0] SM_LO;
  logic         FF;
  logic         OUT_VALID;
  logic         OUT_READY;
  logic [W-1:0] S_OUT;
  logic         OUT_LAST;
  logic [1:0]   CARRY_OUT;
`ifdef PEZ_FINAL_CMP_EN
  logic [W-1:0] M_IN;
  logic         NEED_SUB;

  modport master (
    output START, IN_VALID, SR_S, SR_C, SM, SM_LO, FF, OUT_READY, M_IN,
    input  BUSY, IN_READY, OUT_VALID, S_OUT, OUT_LAST, CARRY_OUT, NEED_SUB
  );
  modport slave (
    input  START, IN_VALID, SR_S, SR_C, SM, SM_LO, FF, OUT_READY, M_IN,
    output BUSY, IN_READY, OUT_VALID, S_OUT, OUT_LAST, CARRY_OUT, NEED_SUB
  );
`else
  modport master (
    output START, IN_VALID, SR_S, SR_C, SM, SM_LO, FF, OUT_READY,
    input  BUSY, IN_READY, OUT_VALID, S_OUT, OUT_LAST, CARRY_OUT
  );
  modport slave (
    input  START, IN_VALID, SR_S, SR_C, SM, SM_LO, FF, OUT_READY,
    output BUSY, IN_READY, OUT_VALID, S_OUT, OUT_LAST, CARRY_OUT
  );
`endif
endinterface

// File: rtl/pez_word_add.sv
// Combinational per-word adder: 3:2 carry-save compression followed by a carry-propagate add.
module pez_word_add #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] c_i,
  input  logic         ff_i,
  input  logic [1:0]   cin_i,
  output logic [W+1:0] sum_o
);

  logic [W-1:0] csa_s;
  logic [W-1:0] csa_c;

  // Compress three operands to sum/carry, then resolve with the injected bit and inter-word carry.
  always_comb begin
    csa_s = a_i ^ b_i ^ c_i;
    csa_c = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
    sum_o = (W+2)'(csa_s) + {1'b0, csa_c, 1'b0} + (W+2)'(ff_i) + (W+2)'(cin_i);
  end

endmodule

// File: rtl/pez_cpa_stream.sv
// Final-stage PE: resolves a carry-save operand stream word by word into binary result words.
// Optional feature macro: PEZ_FINAL_CMP_EN (borrow chain against M_IN, drives NEED_SUB).
module pez_cpa_stream
  import pez_pkg::*;
#(
  parameter int unsigned K      = K_DEF,
  parameter int unsigned W      = W_DEF,
  parameter int unsigned R      = R_DEF,
  parameter int unsigned NWORDS = K / W,
  parameter int unsigned GAP    = W / 2 - 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  pez_cpa_stream_if.slave   bus
);

  localparam int unsigned CNT_BITS = (NWORDS == NWORDS_DEF) ? CNT_W : clogb2(NWORDS);
  localparam int unsigned GAP_BITS = (GAP == GAP_DEF) ? GAP_W : clogb2(GAP + 1);
  localparam logic [W-1:0] LO_MASK = ~W'((1 << R) - 1);

  pez_state_e          state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [GAP_BITS-1:0] gap_q, gap_d;
  logic [1:0]          carry_q, carry_d;
  logic                busy_q, busy_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;
  logic [W-1:0]        s_out_q, s_out_d;
  logic [1:0]          carry_out_q, carry_out_d;

  logic [W-1:0] sm_sub_c;
  logic [W+1:0] sum_c;
  logic         in_ready_c;
  logic         accept_c;
  logic         out_hs_c;
  logic         last_c;

  // Low R bits of the modulus multiple are replaced by the digit.
  assign sm_sub_c = (bus.SM & LO_MASK) | W'(bus.SM_LO);

  pez_word_add #(.W(W)) u_add (
    .a_i   (bus.SR_S),
    .b_i   (bus.SR_C),
    .c_i   (sm_sub_c),
    .ff_i  (bus.FF),
    .cin_i (carry_q),
    .sum_o (sum_c)
  );

`ifdef PEZ_FINAL_CMP_EN
  logic         sub_c_q, sub_c_d;
  logic         need_sub_q, need_sub_d;
  logic [W+1:0] sub_sum_c;

  // Result minus M as result + ~M + 1; sub_c holds the no-borrow bit between words.
  pez_word_add #(.W(W)) u_sub (
    .a_i   (sum_c[W-1:0]),
    .b_i   (~bus.M_IN),
    .c_i   ('0),
    .ff_i  (1'b0),
    .cin_i ({1'b0, sub_c_q}),
    .sum_o (sub_sum_c)
  );

  assign bus.NEED_SUB = need_sub_q;
`endif

  assign in_ready_c = (state_q == ST_ACCEPT) && (!out_valid_q || bus.OUT_READY);
  assign accept_c   = in_ready_c && bus.IN_VALID;
  assign out_hs_c   = out_valid_q && bus.OUT_READY;
  assign last_c     = (cnt_q == CNT_BITS'(NWORDS - 1));

  assign bus.BUSY      = busy_q;
  assign bus.IN_READY  = in_ready_c;
  assign bus.OUT_VALID = out_valid_q;
  assign bus.S_OUT     = s_out_q;
  assign bus.OUT_LAST  = out_last_q;
  assign bus.CARRY_OUT = carry_out_q;

  // Next-state, counters and output register reload.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gap_d       = gap_q;
    carry_d     = carry_q;
    busy_d      = busy_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    s_out_d     = s_out_q;
    carry_out_d = carry_out_q;
`ifdef PEZ_FINAL_CMP_EN
    sub_c_d     = sub_c_q;
    need_sub_d  = need_sub_q;
`endif

    if (out_hs_c) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
`ifdef PEZ_FINAL_CMP_EN
      need_sub_d  = 1'b0;
`endif
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.START) begin
          state_d = ST_ACCEPT;
          cnt_d   = '0;
          carry_d = '0;
          busy_d  = 1'b1;
`ifdef PEZ_FINAL_CMP_EN
          sub_c_d = 1'b1;
`endif
        end
      end
      ST_ACCEPT: begin
        if (accept_c) begin
          s_out_d     = sum_c[W-1:0];
          carry_d     = sum_c[W+1:W];
          carry_out_d = sum_c[W+1:W];
          out_valid_d = 1'b1;
          out_last_d  = last_c;
          cnt_d       = cnt_q + CNT_BITS'(1);
`ifdef PEZ_FINAL_CMP_EN
          sub_c_d     = |sub_sum_c[W+1:W];
          need_sub_d  = last_c && ((sum_c[W+1:W] != 2'b00) || (|sub_sum_c[W+1:W]));
`endif
          if (last_c) begin
            state_d = ST_DRAIN;
          end else if (GAP != 0) begin
            state_d = ST_GAP;
            gap_d   = GAP_BITS'(GAP - 1);
          end
        end
      end
      ST_GAP: begin
        if (gap_q == '0) state_d = ST_ACCEPT;
        else             gap_d   = gap_q - GAP_BITS'(1);
      end
      ST_DRAIN: begin
        if (out_hs_c) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      gap_q       <= '0;
      carry_q     <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      s_out_q     <= '0;
      carry_out_q <= '0;
`ifdef PEZ_FINAL_CMP_EN
      sub_c_q     <= 1'b0;
      need_sub_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      carry_q     <= carry_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      s_out_q     <= s_out_d;
      carry_out_q <= carry_out_d;
`ifdef PEZ_FINAL_CMP_EN
      sub_c_q     <= sub_c_d;
      need_sub_q  <= need_sub_d;
`endif
    end
  end

endmodule

// File: tb/tb_pez_cpa_stream.sv
// Self-checking bench for pez_cpa_stream (K=64, W=16, R=2): scoreboard of expected result words.
module tb_pez_cpa_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pez_cpa_stream_if #(.W(16), .R(2)) bus ();
  pez_cpa_stream_if #(.W(16), .R(2)) bus6 ();

  pez_cpa_stream #(.K(64), .W(16), .R(2), .NWORDS(4), .GAP(0)) dut (
    .CLK(clk), .RST_N(rst_n), .bus(bus)
  );

  pez_cpa_stream #(.K(64), .W(16), .R(2), .NWORDS(4), .GAP(6)) dut6 (
    .CLK(clk), .RST_N(rst_n), .bus(bus6)
  );

  typedef struct {
    logic [15:0] data;
    logic        last;
    logic [1:0]  carry;
    logic        nsub;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;
  int   hs_cnt = 0;

  logic [15:0] st_s [4];
  logic [15:0] st_c [4];
  logic [15:0] st_sm[4];
  logic [1:0]  st_lo[4];
  logic        st_ff[4];
  logic [15:0] st_m [4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_stim(input logic [15:0] s, input logic [15:0] c, input logic [15:0] sm,
                          input logic [1:0] lo, input logic ff);
    for (int i = 0; i < 4; i++) begin
      st_s[i] = s; st_c[i] = c; st_sm[i] = sm; st_lo[i] = lo; st_ff[i] = ff; st_m[i] = 16'h0;
    end
  endtask

  // Drives one operation of n words, pushing the reference result of each accepted word.
  task automatic send_op(input int n, input bit dbl_start, output int stalls);
    int          mc;
    int          bud;
    logic [17:0] t;
    logic [63:0] res;
    logic [63:0] mv;
    exp_t        e;
    stalls = 0; mc = 0; res = '0; mv = '0;
    @(posedge clk); #1 bus.START = 1'b1;
    @(posedge clk); #1 bus.START = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.IN_VALID = 1'b1;
      bus.SR_S = st_s[i]; bus.SR_C = st_c[i]; bus.SM = st_sm[i];
      bus.SM_LO = st_lo[i]; bus.FF = st_ff[i];
`ifdef PEZ_FINAL_CMP_EN
      bus.M_IN = st_m[i];
`endif
      bus.START = dbl_start && (i == 2);
      bud = 0;
      @(negedge clk);
      while (!bus.IN_READY && bud < 50) begin
        stalls++; bud++;
        @(negedge clk);
      end
      if (!bus.IN_READY) begin
        chk("in_ready_timeout", 32'(bus.IN_READY), 32'd1);
        bus.IN_VALID = 1'b0;
        return;
      end
      t = 18'(st_s[i]) + 18'(st_c[i]) + 18'((st_sm[i] & 16'hFFFC) | 16'(st_lo[i]))
        + 18'(st_ff[i]) + 18'(mc);
      mc = int'(t[17:16]);
      res = res | (64'(t[15:0]) << (16 * i));
      mv  = mv  | (64'(st_m[i]) << (16 * i));
      e.data = t[15:0]; e.last = (i == 3); e.carry = t[17:16];
      e.nsub = (t[17:16] != 2'b00) || (res >= mv);
      sb.push_back(e);
      @(posedge clk); #1 bus.START = 1'b0;
    end
    bus.IN_VALID = 1'b0;
  endtask

  task automatic wait_idle();
    int bud;
    bud = 0;
    @(negedge clk);
    while (bus.BUSY && bud < 100) begin
      bud++;
      @(negedge clk);
    end
    chk("busy_drop", 32'(bus.BUSY), 32'd0);
  endtask

  // Output monitor: every completed handshake is checked against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && bus.OUT_VALID && bus.OUT_READY) begin
      hs_cnt++;
      if (sb.size() == 0) begin
        chk("sb_unexpected", 32'(sb.size()), 32'd1);
      end else begin
        mon_e = sb.pop_front();
        chk("s_out", 32'(bus.S_OUT), 32'(mon_e.data));
        chk("out_last", 32'(bus.OUT_LAST), 32'(mon_e.last));
        if (mon_e.last) begin
          chk("carry_out", 32'(bus.CARRY_OUT), 32'(mon_e.carry));
`ifdef PEZ_FINAL_CMP_EN
          chk("need_sub", 32'(bus.NEED_SUB), 32'(mon_e.nsub));
`endif
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int   stalls;
    int   bud;
    int   hs_base;
    int   cyc, acc, zeros, first_acc, last_acc;
    logic [15:0] held;

    bus.START = 0; bus.IN_VALID = 0; bus.SR_S = 0; bus.SR_C = 0; bus.SM = 0;
    bus.SM_LO = 0; bus.FF = 0; bus.OUT_READY = 1;
    bus6.START = 0; bus6.IN_VALID = 0; bus6.SR_S = 0; bus6.SR_C = 0; bus6.SM = 0;
    bus6.SM_LO = 0; bus6.FF = 0; bus6.OUT_READY = 1;
`ifdef PEZ_FINAL_CMP_EN
    bus.M_IN = 0; bus6.M_IN = 0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(bus.BUSY), 32'd0);
    chk("rst_in_ready", 32'(bus.IN_READY), 32'd0);
    chk("rst_out_valid", 32'(bus.OUT_VALID), 32'd0);
    chk("rst_out_last", 32'(bus.OUT_LAST), 32'd0);
    chk("rst_s_out", 32'(bus.S_OUT), 32'd0);
    chk("rst_carry_out", 32'(bus.CARRY_OUT), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // IN_VALID while idle is ignored.
    bus.IN_VALID = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 32'(bus.IN_READY), 32'd0);
    @(negedge clk);
    chk("idle_out_valid", 32'(bus.OUT_VALID), 32'd0);
    bus.IN_VALID = 1'b0;

    // Test 1: single injected bit, full throughput.
    set_stim(16'h0, 16'h0, 16'h0, 2'd0, 1'b0);
    st_ff[0] = 1'b1;
    send_op(4, 1'b0, stalls);
    chk("thru_stalls", 32'(stalls), 32'd0);
    wait_idle();

    // Test 2: all-ones carry chain, with a START pulse mid-operation that must be ignored.
    set_stim(16'hFFFF, 16'hFFFF, 16'hFFFC, 2'd3, 1'b1);
    send_op(4, 1'b1, stalls);
    wait_idle();

    // Test 4: backpressure on word 1 for 5 cycles.
    for (int i = 0; i < 4; i++) begin
      st_s[i] = 16'($urandom); st_c[i] = 16'($urandom); st_sm[i] = 16'($urandom);
      st_lo[i] = 2'($urandom); st_ff[i] = 1'($urandom);
    end
    hs_base = hs_cnt;
    fork
      send_op(4, 1'b0, stalls);
      begin
        bud = 0;
        do begin
          @(posedge clk); #1;
          bud++;
        end while (!(bus.OUT_VALID && hs_cnt == hs_base + 1) && bud < 100);
        chk("bp_armed", 32'(bud < 100), 32'd1);
        bus.OUT_READY = 1'b0;
        held = bus.S_OUT;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk("bp_hold_s", 32'(bus.S_OUT), 32'(held));
          chk("bp_hold_valid", 32'(bus.OUT_VALID), 32'd1);
          chk("bp_in_ready", 32'(bus.IN_READY), 32'd0);
        end
        @(posedge clk); #1 bus.OUT_READY = 1'b1;
      end
    join
    wait_idle();

    // Test 5: reset after word 2, then a clean zero operation.
    set_stim(16'hFFFF, 16'hFFFF, 16'hFFFC, 2'd3, 1'b1);
    send_op(3, 1'b0, stalls);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(bus.BUSY), 32'd0);
    chk("mid_rst_in_ready", 32'(bus.IN_READY), 32'd0);
    chk("mid_rst_out_valid", 32'(bus.OUT_VALID), 32'd0);
    chk("mid_rst_out_last", 32'(bus.OUT_LAST), 32'd0);
    chk("mid_rst_s_out", 32'(bus.S_OUT), 32'd0);
    chk("mid_rst_carry_out", 32'(bus.CARRY_OUT), 32'd0);
    sb.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    set_stim(16'h0, 16'h0, 16'h0, 2'd0, 1'b0);
    send_op(4, 1'b0, stalls);
    wait_idle();

    // Test 3: GAP=6 instance with IN_VALID held high.
    @(posedge clk); #1 bus6.START = 1'b1;
    @(posedge clk); #1 bus6.START = 1'b0; bus6.IN_VALID = 1'b1;
    cyc = 0; acc = 0; zeros = 0; first_acc = 0; last_acc = 0;
    while (acc < 4 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (bus6.IN_READY) begin
        acc++;
        if (acc == 1) first_acc = cyc;
        else chk("gap_len", 32'(zeros), 32'd6);
        last_acc = cyc;
        zeros = 0;
      end else if (acc > 0) begin
        zeros++;
      end
    end
    chk("gap_accepts", 32'(acc), 32'd4);
    chk("gap_span", 32'(last_acc - first_acc + 1), 32'd22);
    @(posedge clk); #1 bus6.IN_VALID = 1'b0;
    bud = 0;
    @(negedge clk);
    while (bus6.BUSY && bud < 100) begin
      bud++;
      @(negedge clk);
    end
    chk("gap_busy_drop", 32'(bus6.BUSY), 32'd0);

`ifdef PEZ_FINAL_CMP_EN
    // Test 6: result equal to M, then result equal to M-1.
    set_stim(16'h0, 16'h0, 16'h0, 2'd0, 1'b0);
    st_s[0] = 16'h1234; st_s[1] = 16'h5678; st_s[2] = 16'h9ABC; st_s[3] = 16'h0DEF;
    for (int i = 0; i < 4; i++) st_m[i] = st_s[i];
    send_op(4, 1'b0, stalls);
    wait_idle();
    st_m[0] = 16'h1235;
    send_op(4, 1'b0, stalls);
    wait_idle();
`endif

    repeat (2) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
